// File: rtl/tl_c_channel_arbiter.sv
// ---------------------------------------------------------------------------
// tl_c_channel_arbiter
//
// Purpose:
//   Shares the single L1 TileLink C channel between the probe unit
//   (ProbeAck / ProbeAckData) and the writeback unit (Release / ReleaseData).
//   In IDLE a winner is picked combinationally every cycle. If the winner's
//   first beat carries data and BEATS > 1, the channel is locked to it until
//   its last beat fires. A registered one-cycle done pulse tells each unit
//   that its message has left.
//
// Optional feature (macro TL_C_ARB_RR_EN):
//   defined   - round-robin arbitration in IDLE. rr_last records the last
//               first-beat winner (0 = probe, 1 = release), and on a tie the
//               other requester wins. PROBE_FIRST is ignored.
//   undefined - fixed priority chosen by PROBE_FIRST; there is no rr_last.
//
// Parameters:
//   BEATS       beats per data-carrying C message (power of 2, >= 1)
//   CNT_W       beat counter width, $clog2(BEATS) with a minimum of 1
//   PROBE_FIRST 1 = probe beats writeback, 0 = writeback beats probe
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   prb_valid/bits/ready  probe unit C beat source
//   rel_valid/bits/ready  writeback unit C beat source
//   c_valid/bits/ready    outer TL C port
//   prb_done, rel_done    one-cycle pulse after the last beat of a message
//   busy                  arbiter locked mid-burst (FSM in BURST)
//   beat_cnt              beat index inside the locked burst
//
// Handshake (all three interfaces): a beat transfers on a rising clk edge
// where valid and ready are both 1. A valid, once raised by the locked
// requester, is expected to hold its header until the beat fires; ready
// may be raised without valid. c_ready never feeds back into either valid.
// ---------------------------------------------------------------------------

package BundleST;

    localparam int SOURCE_W = 8;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 128;

    // C channel opcodes used by the L1.
    localparam logic [2:0] OP_PROBE_ACK      = 3'd4;
    localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;
    localparam logic [2:0] OP_RELEASE        = 3'd6;
    localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [3:0]          size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W-1:0]   data;
        logic                corrupt;
    } TLBundleCST;

    // Data-carrying C opcodes all have bit 0 set.
    function automatic logic has_data(input logic [2:0] opcode);
        return opcode[0];
    endfunction

endpackage

module tl_c_channel_arbiter
    import BundleST::*;
#(
    parameter int BEATS       = 4,
    parameter int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1,
    parameter int PROBE_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             prb_valid,
    input  TLBundleCST       prb_bits,
    output logic             prb_ready,

    input  logic             rel_valid,
    input  TLBundleCST       rel_bits,
    output logic             rel_ready,

    output logic             c_valid,
    output TLBundleCST       c_bits,
    input  logic             c_ready,

    output logic             prb_done,
    output logic             rel_done,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam bit               MULTI_BEAT = (BEATS > 1);

    state_t state;
    logic   lock_sel;      // locked requester: 0 = probe, 1 = release

    logic   win_rel;       // IDLE arbitration result: 1 = release wins
    logic   sel_rel;       // requester currently owning the channel
    logic   sel_valid;
    logic   fire;
    logic   msg_has_data;
    logic   last_beat;

    // -----------------------------------------------------------------------
    // IDLE arbitration. Only valids feed this, never c_ready.
    // -----------------------------------------------------------------------
`ifdef TL_C_ARB_RR_EN
    logic rr_last;         // last first-beat winner: 0 = probe, 1 = release

    always_comb begin
        win_rel = 1'b0;
        if (prb_valid && rel_valid) begin
            // Tie goes to whoever did not win last time.
            win_rel = ~rr_last;
        end else begin
            win_rel = rel_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last <= 1'b0;
        end else if (state == IDLE && fire) begin
            rr_last <= sel_rel;
        end
    end
`else
    always_comb begin
        win_rel = 1'b0;
        if (PROBE_FIRST != 0) begin
            win_rel = rel_valid & ~prb_valid;
        end else begin
            win_rel = rel_valid;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Channel mux and handshake
    // -----------------------------------------------------------------------
    always_comb begin
        sel_rel   = (state == BURST) ? lock_sel : win_rel;
        sel_valid = sel_rel ? rel_valid : prb_valid;

        // Reset masks every valid/ready leaving the block.
        c_valid   = rst_n & sel_valid;
        prb_ready = rst_n & ~sel_rel & c_ready;
        rel_ready = rst_n &  sel_rel & c_ready;

        // With nothing presented, the payload defaults to the writeback side.
        c_bits    = (c_valid && !sel_rel) ? prb_bits : rel_bits;

        fire         = c_valid & c_ready;
        msg_has_data = has_data(c_bits.opcode);
        last_beat    = (beat_cnt == LAST_BEAT);
    end

    // -----------------------------------------------------------------------
    // Lock FSM with registered busy / beat_cnt / done outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            lock_sel <= 1'b0;
            beat_cnt <= '0;
            busy     <= 1'b0;
            prb_done <= 1'b0;
            rel_done <= 1'b0;
        end else begin
            prb_done <= 1'b0;
            rel_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire) begin
                        if (msg_has_data && MULTI_BEAT) begin
                            // First beat already left; next expected is beat 1.
                            state    <= BURST;
                            lock_sel <= sel_rel;
                            beat_cnt <= CNT_ONE;
                            busy     <= 1'b1;
                        end else begin
                            prb_done <= ~sel_rel;
                            rel_done <=  sel_rel;
                        end
                    end
                end
                BURST: begin
                    if (fire) begin
                        if (last_beat) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                            prb_done <= ~lock_sel;
                            rel_done <=  lock_sel;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Simulation-only protocol checks
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    logic [2:0]          hdr_opcode;
    logic [SOURCE_W-1:0] hdr_source;
    logic [ADDR_W-1:0]   hdr_address;

    // Header of the burst as seen on its first beat.
    always_ff @(posedge clk) begin
        if (state == IDLE && fire) begin
            hdr_opcode  <= c_bits.opcode;
            hdr_source  <= c_bits.source;
            hdr_address <= c_bits.address;
        end
    end

    a_hdr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state == BURST && fire) |->
            (c_bits.opcode == hdr_opcode && c_bits.source == hdr_source &&
             c_bits.address == hdr_address))
        else $error("locked requester changed opcode/source/address mid-burst");

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
        beat_cnt <= LAST_BEAT)
        else $error("beat_cnt beyond last beat");

    a_busy_state: assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state == BURST))
        else $error("busy disagrees with FSM state");

    a_idle_cnt: assert property (@(posedge clk) disable iff (!rst_n)
        (state == IDLE) |-> (beat_cnt == '0))
        else $error("beat_cnt nonzero while idle");

    a_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(prb_done && rel_done))
        else $error("both done pulses asserted together");

    a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
        !(prb_ready && rel_ready))
        else $error("both requesters granted");
`endif

endmodule

// File: tb/tb_tl_c_channel_arbiter.sv
module tb_tl_c_channel_arbiter;
    import BundleST::*;

    logic       clk;
    logic       rst_n;
    logic       prb_valid;
    TLBundleCST prb_bits;
    logic       prb_ready;
    logic       rel_valid;
    TLBundleCST rel_bits;
    logic       rel_ready;
    logic       c_valid;
    TLBundleCST c_bits;
    logic       c_ready;
    logic       prb_done;
    logic       rel_done;
    logic       busy;
    logic [1:0] beat_cnt;

    int total;
    int bad;

    tl_c_channel_arbiter #(
        .BEATS       (4),
        .PROBE_FIRST (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .prb_valid (prb_valid),
        .prb_bits  (prb_bits),
        .prb_ready (prb_ready),
        .rel_valid (rel_valid),
        .rel_bits  (rel_bits),
        .rel_ready (rel_ready),
        .c_valid   (c_valid),
        .c_bits    (c_bits),
        .c_ready   (c_ready),
        .prb_done  (prb_done),
        .rel_done  (rel_done),
        .busy      (busy),
        .beat_cnt  (beat_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, got timeout required finish");
        $fatal(1);
    end

    // Move to just after the next active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic TLBundleCST mk(input logic [2:0] op, input logic [7:0] src,
                                      input logic [31:0] addr, input logic [127:0] data);
        TLBundleCST b;
        b         = '0;
        b.opcode  = op;
        b.size    = 4'd6;
        b.source  = src;
        b.address = addr;
        b.data    = data;
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        prb_valid = 1'b1;
        rel_valid = 1'b1;
        prb_bits  = mk(OP_PROBE_ACK, 8'h01, 32'h1000, 128'h0);
        rel_bits  = mk(OP_RELEASE, 8'h02, 32'h2000, 128'h0);
        c_ready   = 1'b1;
        step();
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL reset_c_valid got %b want 0", c_valid); end
        total++; if (prb_ready !== 1'b0) begin bad++; $display("FAIL reset_prb_ready got %b want 0", prb_ready); end
        total++; if (rel_ready !== 1'b0) begin bad++; $display("FAIL reset_rel_ready got %b want 0", rel_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
        total++; if (beat_cnt !== 2'd0) begin bad++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
        total++; if ({prb_done, rel_done} !== 2'b00) begin bad++; $display("FAIL reset_done got %b want 00", {prb_done, rel_done}); end
        rst_n     = 1'b1;
        prb_valid = 1'b0;
        rel_valid = 1'b0;
        step();
    endtask

    task automatic test_probe_ack();
        prb_valid = 1'b1;
        prb_bits  = mk(OP_PROBE_ACK, 8'h11, 32'h0000_4000, 128'h0);
        c_ready   = 1'b1;
        #1;
        total++; if (c_valid !== 1'b1) begin bad++; $display("FAIL pa_c_valid got %b want 1", c_valid); end
        total++; if (c_bits !== prb_bits) begin bad++; $display("FAIL pa_c_bits got %h want %h", c_bits, prb_bits); end
        total++; if ({prb_ready, rel_ready} !== 2'b10) begin bad++; $display("FAIL pa_ready got %b want 10", {prb_ready, rel_ready}); end
        step();
        prb_valid = 1'b0;
        total++; if (prb_done !== 1'b1) begin bad++; $display("FAIL pa_prb_done got %b want 1", prb_done); end
        total++; if (rel_done !== 1'b0) begin bad++; $display("FAIL pa_rel_done got %b want 0", rel_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pa_busy got %b want 0", busy); end
        step();
        total++; if (prb_done !== 1'b0) begin bad++; $display("FAIL pa_done_width got %b want 0", prb_done); end
    endtask

    task automatic test_release_data();
        logic [1:0] exp_cnt [4];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd0;
        rel_valid = 1'b1;
        rel_bits  = mk(OP_RELEASE_DATA, 8'h22, 32'h0000_8000, 128'hA0);
        c_ready   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (rel_ready !== 1'b1) begin bad++; $display("FAIL rd_rel_ready beat %0d got %b want 1", i, rel_ready); end
            step();
            total++; if (beat_cnt !== exp_cnt[i]) begin bad++; $display("FAIL rd_beat_cnt beat %0d got %0d want %0d", i, beat_cnt, exp_cnt[i]); end
            total++; if (busy !== (i < 3)) begin bad++; $display("FAIL rd_busy beat %0d got %b want %b", i, busy, (i < 3)); end
            total++; if (rel_done !== (i == 3)) begin bad++; $display("FAIL rd_rel_done beat %0d got %b want %b", i, rel_done, (i == 3)); end
            if (i < 3) rel_bits.data = 128'hA1 + 128'(i);
            else rel_valid = 1'b0;
        end
        step();
        total++; if (rel_done !== 1'b0) begin bad++; $display("FAIL rd_done_width got %b want 0", rel_done); end
    endtask

    task automatic test_priority();
        prb_bits  = mk(OP_PROBE_ACK, 8'h31, 32'h0000_C000, 128'h0);
        rel_bits  = mk(OP_RELEASE, 8'h32, 32'h0000_D000, 128'h0);
        prb_valid = 1'b1;
        rel_valid = 1'b1;
        c_ready   = 1'b1;
`ifdef TL_C_ARB_RR_EN
        // Last winner was the release, so the probe goes first, then alternate.
        for (int i = 0; i < 4; i++) begin
            logic exp_rel;
            exp_rel = (i % 2 == 1);
            #1;
            total++; if ({prb_ready, rel_ready} !== {~exp_rel, exp_rel}) begin bad++; $display("FAIL rr_ready msg %0d got %b want %b", i, {prb_ready, rel_ready}, {~exp_rel, exp_rel}); end
            step();
            total++; if ({prb_done, rel_done} !== {~exp_rel, exp_rel}) begin bad++; $display("FAIL rr_done msg %0d got %b want %b", i, {prb_done, rel_done}, {~exp_rel, exp_rel}); end
        end
        prb_valid = 1'b0;
        rel_valid = 1'b0;
        step();
`else
        #1;
        total++; if ({prb_ready, rel_ready} !== 2'b10) begin bad++; $display("FAIL pri_first_ready got %b want 10", {prb_ready, rel_ready}); end
        total++; if (c_bits !== prb_bits) begin bad++; $display("FAIL pri_first_bits got %h want %h", c_bits, prb_bits); end
        step();
        prb_valid = 1'b0;
        total++; if (prb_done !== 1'b1) begin bad++; $display("FAIL pri_prb_done got %b want 1", prb_done); end
        #1;
        total++; if ({prb_ready, rel_ready} !== 2'b01) begin bad++; $display("FAIL pri_second_ready got %b want 01", {prb_ready, rel_ready}); end
        total++; if (c_bits !== rel_bits) begin bad++; $display("FAIL pri_second_bits got %h want %h", c_bits, rel_bits); end
        step();
        rel_valid = 1'b0;
        total++; if ({prb_done, rel_done} !== 2'b01) begin bad++; $display("FAIL pri_rel_done got %b want 01", {prb_done, rel_done}); end
        step();
`endif
    endtask

    task automatic test_lock();
        rel_valid = 1'b1;
        rel_bits  = mk(OP_RELEASE_DATA, 8'h41, 32'h0001_0000, 128'hB0);
        prb_valid = 1'b0;
        c_ready   = 1'b1;
        step();
        total++; if (beat_cnt !== 2'd1) begin bad++; $display("FAIL lk_start_cnt got %0d want 1", beat_cnt); end
        prb_valid = 1'b1;
        prb_bits  = mk(OP_PROBE_ACK, 8'h42, 32'h0002_0000, 128'h0);
        for (int i = 1; i < 4; i++) begin
            rel_bits.data = 128'hB0 + 128'(i);
            #1;
            total++; if ({prb_ready, rel_ready} !== 2'b01) begin bad++; $display("FAIL lk_ready beat %0d got %b want 01", i, {prb_ready, rel_ready}); end
            total++; if (c_bits !== rel_bits) begin bad++; $display("FAIL lk_bits beat %0d got %h want %h", i, c_bits, rel_bits); end
            step();
        end
        rel_valid = 1'b0;
        total++; if (rel_done !== 1'b1) begin bad++; $display("FAIL lk_rel_done got %b want 1", rel_done); end
        #1;
        total++; if (prb_ready !== 1'b1) begin bad++; $display("FAIL lk_probe_on_done got %b want 1", prb_ready); end
        total++; if (c_bits !== prb_bits) begin bad++; $display("FAIL lk_probe_bits got %h want %h", c_bits, prb_bits); end
        step();
        prb_valid = 1'b0;
        total++; if (prb_done !== 1'b1) begin bad++; $display("FAIL lk_prb_done got %b want 1", prb_done); end
        step();
    endtask

    task automatic test_ready_toggle();
        int fires;
        logic [1:0] exp_cnt;
        fires     = 0;
        prb_valid = 1'b1;
        prb_bits  = mk(OP_PROBE_ACK_DATA, 8'h51, 32'h0003_0000, 128'hC0);
        rel_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            c_ready = (j % 2 == 0);
            #1;
            total++; if (c_valid !== (j < 7)) begin bad++; $display("FAIL tg_c_valid cyc %0d got %b want %b", j, c_valid, (j < 7)); end
            if (c_valid && c_ready) fires++;
            step();
            exp_cnt = 2'((j / 2 + 1) % 4);
            total++; if (beat_cnt !== exp_cnt) begin bad++; $display("FAIL tg_beat_cnt cyc %0d got %0d want %0d", j, beat_cnt, exp_cnt); end
            total++; if (prb_done !== (j == 6)) begin bad++; $display("FAIL tg_prb_done cyc %0d got %b want %b", j, prb_done, (j == 6)); end
            if (j % 2 == 0) prb_bits.data = prb_bits.data + 128'd1;
            if (j == 6) prb_valid = 1'b0;
        end
        total++; if (fires != 4) begin bad++; $display("FAIL tg_fire_count got %0d want 4", fires); end
        c_ready = 1'b1;
    endtask

    task automatic test_reset_mid_burst();
        rel_valid = 1'b1;
        rel_bits  = mk(OP_RELEASE_DATA, 8'h61, 32'h0004_0000, 128'hD0);
        c_ready   = 1'b1;
        step();
        rel_bits.data = 128'hD1;
        step();
        total++; if (beat_cnt !== 2'd2) begin bad++; $display("FAIL rm_pre_cnt got %0d want 2", beat_cnt); end
        rst_n = 1'b0;
        #1;
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL rm_c_valid_in_reset got %b want 0", c_valid); end
        total++; if (rel_ready !== 1'b0) begin bad++; $display("FAIL rm_rel_ready_in_reset got %b want 0", rel_ready); end
        step();
        rst_n     = 1'b1;
        rel_valid = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got %b want 0", busy); end
        total++; if (beat_cnt !== 2'd0) begin bad++; $display("FAIL rm_beat_cnt got %0d want 0", beat_cnt); end
        total++; if (c_valid !== 1'b0) begin bad++; $display("FAIL rm_c_valid got %b want 0", c_valid); end
        total++; if (rel_done !== 1'b0) begin bad++; $display("FAIL rm_rel_done got %b want 0", rel_done); end
        step();
        total++; if (rel_done !== 1'b0) begin bad++; $display("FAIL rm_rel_done_late got %b want 0", rel_done); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_probe_ack();
        test_release_data();
        test_priority();
        test_lock();
        test_ready_toggle();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
